// File: rtl/dp_ram_arbiter.sv
// rtl/dp_ram_arbiter.sv - round-robin two-port arbiter for a shared true dual port RAM (optional DP_RAM_ARBITER_CONFLICT_CNT_EN)
module dp_ram_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    // $clog2(RAM_DEPTH) equals clogb2(RAM_DEPTH-1) for any depth >= 2
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic                           clka,
    input  logic                           rsta,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*AW-1:0]          req_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ*RAM_WIDTH-1:0]   rsp_rdata,
    output logic [AW-1:0]                  ram_addra,
    output logic [AW-1:0]                  ram_addrb,
    output logic [RAM_WIDTH-1:0]           ram_dina,
    output logic [RAM_WIDTH-1:0]           ram_dinb,
    output logic                           ram_wea,
    output logic                           ram_web,
    output logic                           ram_ena,
    output logic                           ram_enb,
    output logic                           ram_regcea,
    output logic                           ram_regceb,
    output logic                           ram_rsta,
    output logic                           ram_rstb,
`ifdef DP_RAM_ARBITER_CONFLICT_CNT_EN
    output logic [15:0]                    conflict_cnt,
`endif
    input  logic [RAM_WIDTH-1:0]           ram_douta,
    input  logic [RAM_WIDTH-1:0]           ram_doutb
);

    localparam int LAT = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [AW-1:0]        addr_arr  [NUM_REQ];
    logic [RAM_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic [IW-1:0] ptr_q, ptr_d;
    logic          a_vld, b_vld, b_ok, collide;
    logic [IW-1:0] a_idx, b_idx, last_idx;
    logic          a_rd, b_rd;

    logic [LAT-1:0] pa_v_q, pb_v_q;
    logic [IW-1:0]  pa_i_q [LAT];
    logic [IW-1:0]  pb_i_q [LAT];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign addr_arr[g]  = req_addr[g*AW +: AW];
            assign wdata_arr[g] = req_wdata[g*RAM_WIDTH +: RAM_WIDTH];
        end
    endgenerate

    // Scan from ptr: first valid requester takes port A, second takes port B
    always_comb begin : arb_scan
        logic [IW:0] cand;
        a_vld = 1'b0;
        a_idx = '0;
        b_vld = 1'b0;
        b_idx = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!rsta && req_valid[cand[IW-1:0]]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = cand[IW-1:0];
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = cand[IW-1:0];
                end
            end
        end
    end

    // Same address with any write on either side would race inside the RAM, so B backs off
    always_comb begin
        collide = a_vld && b_vld && (addr_arr[a_idx] == addr_arr[b_idx])
                  && (req_we[a_idx] || req_we[b_idx]);
        b_ok    = b_vld && !collide;
        a_rd    = a_vld && !req_we[a_idx];
        b_rd    = b_ok && !req_we[b_idx];
    end

    // One-hot-per-port grant vector back to the requesters
    always_comb begin
        req_ready = '0;
        if (a_vld) begin
            req_ready[a_idx] = 1'b1;
        end
        if (b_ok) begin
            req_ready[b_idx] = 1'b1;
        end
    end

    // RAM control and data; idle ports are driven to zero
    always_comb begin
        ram_ena   = a_vld;
        ram_wea   = a_vld && req_we[a_idx];
        ram_addra = a_vld ? addr_arr[a_idx]  : '0;
        ram_dina  = a_vld ? wdata_arr[a_idx] : '0;
        ram_enb   = b_ok;
        ram_web   = b_ok && req_we[b_idx];
        ram_addrb = b_ok ? addr_arr[b_idx]  : '0;
        ram_dinb  = b_ok ? wdata_arr[b_idx] : '0;
    end

    assign ram_rsta = rsta;
    assign ram_rstb = rsta;

    // Pointer moves just past the last requester served this cycle
    always_comb begin
        last_idx = b_ok ? b_idx : a_idx;
        ptr_d    = ptr_q;
        if (a_vld) begin
            ptr_d = (last_idx == IW'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clka) begin
        if (rsta) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Per-port read tracking: {valid, requester} shifted once per cycle for LAT stages
    always_ff @(posedge clka) begin
        if (rsta) begin
            pa_v_q <= '0;
            pb_v_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                pa_i_q[s] <= '0;
                pb_i_q[s] <= '0;
            end
        end else begin
            pa_v_q[0] <= a_rd;
            pb_v_q[0] <= b_rd;
            pa_i_q[0] <= a_idx;
            pb_i_q[0] <= b_idx;
            for (int s = 1; s < LAT; s++) begin
                pa_v_q[s] <= pa_v_q[s-1];
                pb_v_q[s] <= pb_v_q[s-1];
                pa_i_q[s] <= pa_i_q[s-1];
                pb_i_q[s] <= pb_i_q[s-1];
            end
        end
    end

    generate
        if (LAT == 2) begin : g_regce_hp
            // Output register loads only in the cycle after a read was issued
            assign ram_regcea = pa_v_q[0];
            assign ram_regceb = pb_v_q[0];
        end else begin : g_regce_ll
            assign ram_regcea = 1'b1;
            assign ram_regceb = 1'b1;
        end
    endgenerate

    // Route RAM read data to the requester recorded in the last pipeline stage
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rsta && pa_v_q[LAT-1] && (pa_i_q[LAT-1] == IW'(i))) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH] = ram_douta;
            end
            if (!rsta && pb_v_q[LAT-1] && (pb_i_q[LAT-1] == IW'(i))) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH] = ram_doutb;
            end
        end
    end

`ifdef DP_RAM_ARBITER_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q;

    // Saturating count of cycles where port B was withheld by the collision rule
    always_ff @(posedge clka) begin
        if (rsta) begin
            conflict_cnt_q <= '0;
        end else if (collide && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// tb/tb_dp_ram_arbiter.sv - scoreboard bench for dp_ram_arbiter (optional DP_RAM_ARBITER_CONFLICT_CNT_EN)
module tb_dp_ram_arbiter;

    logic        clka;
    logic        rsta;
    logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [39:0] req_addr;
    logic [71:0] req_wdata, rsp_rdata;
    logic [9:0]  ram_addra, ram_addrb;
    logic [17:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
    logic        ram_wea, ram_web, ram_ena, ram_enb, ram_regcea, ram_regceb, ram_rsta, ram_rstb;

    logic [3:0]  l_req_valid, l_req_we, l_req_ready, l_rsp_valid;
    logic [39:0] l_req_addr;
    logic [71:0] l_req_wdata, l_rsp_rdata;
    logic [9:0]  l_addra, l_addrb;
    logic [17:0] l_dina, l_dinb, l_douta, l_doutb;
    logic        l_wea, l_web, l_ena, l_enb, l_regcea, l_regceb, l_rsta, l_rstb;
`ifdef DP_RAM_ARBITER_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt, l_conflict_cnt;
`endif

    dp_ram_arbiter #(.RAM_PERFORMANCE("HIGH_PERFORMANCE")) dut (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dina(ram_dina), .ram_dinb(ram_dinb),
        .ram_wea(ram_wea), .ram_web(ram_web), .ram_ena(ram_ena), .ram_enb(ram_enb),
        .ram_regcea(ram_regcea), .ram_regceb(ram_regceb), .ram_rsta(ram_rsta), .ram_rstb(ram_rstb),
`ifdef DP_RAM_ARBITER_CONFLICT_CNT_EN
        .conflict_cnt(conflict_cnt),
`endif
        .ram_douta(ram_douta), .ram_doutb(ram_doutb)
    );

    dp_ram_arbiter #(.RAM_PERFORMANCE("LOW_LATENCY")) dut_ll (
        .clka(clka), .rsta(rsta), .req_valid(l_req_valid), .req_we(l_req_we),
        .req_addr(l_req_addr), .req_wdata(l_req_wdata), .req_ready(l_req_ready),
        .rsp_valid(l_rsp_valid), .rsp_rdata(l_rsp_rdata),
        .ram_addra(l_addra), .ram_addrb(l_addrb), .ram_dina(l_dina), .ram_dinb(l_dinb),
        .ram_wea(l_wea), .ram_web(l_web), .ram_ena(l_ena), .ram_enb(l_enb),
        .ram_regcea(l_regcea), .ram_regceb(l_regceb), .ram_rsta(l_rsta), .ram_rstb(l_rstb),
`ifdef DP_RAM_ARBITER_CONFLICT_CNT_EN
        .conflict_cnt(l_conflict_cnt),
`endif
        .ram_douta(l_douta), .ram_doutb(l_doutb)
    );

    // Write-first true dual port RAM, HIGH_PERFORMANCE flavour (extra output register)
    logic [17:0] mem [1024];
    logic [17:0] ra, rb;
    always @(posedge clka) begin
        if (ram_ena) begin
            if (ram_wea) begin mem[ram_addra] <= ram_dina; ra <= ram_dina; end
            else ra <= mem[ram_addra];
        end
        if (ram_enb) begin
            if (ram_web) begin mem[ram_addrb] <= ram_dinb; rb <= ram_dinb; end
            else rb <= mem[ram_addrb];
        end
        if (ram_rsta) ram_douta <= '0; else if (ram_regcea) ram_douta <= ra;
        if (ram_rstb) ram_doutb <= '0; else if (ram_regceb) ram_doutb <= rb;
    end

    // Write-first true dual port RAM, LOW_LATENCY flavour
    logic [17:0] l_mem [1024];
    always @(posedge clka) begin
        if (l_ena) begin
            if (l_wea) begin l_mem[l_addra] <= l_dina; l_douta <= l_dina; end
            else l_douta <= l_mem[l_addra];
        end
        if (l_enb) begin
            if (l_web) begin l_mem[l_addrb] <= l_dinb; l_doutb <= l_dinb; end
            else l_doutb <= l_mem[l_addrb];
        end
    end

    initial clka = 1'b0;
    always #5 clka = ~clka;

    typedef struct { int due; int idx; logic [17:0] data; } sb_t;
    sb_t         sb[$];
    logic [17:0] mirror [1024];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          gcnt[4];
    int          wcnt[4];
    int          maxw;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0; l_mem[i] = '0; mirror[i] = '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [9:0] a, input logic [17:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*10 +: 10]  = a;
        req_wdata[i*18 +: 18] = d;
    endtask

    task automatic clr_req();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_l(input logic v, input logic we, input logic [9:0] a, input logic [17:0] d);
        l_req_valid = {3'b000, v}; l_req_we = {3'b000, we};
        l_req_addr = {30'd0, a};   l_req_wdata = {54'd0, d};
    endtask

    // Check grants and due responses, record transfers, then advance one clock
    task automatic step(input logic [3:0] exp_rdy);
        sb_t e;
        int  n;
        #1;
        chk("req_ready", req_ready, exp_rdy);
        n = 0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("rsp_valid_bit", rsp_valid[e.idx], 1'b1);
            chk("rsp_rdata", rsp_rdata[e.idx*18 +: 18], e.data);
            n++;
        end
        chk("rsp_count", $countones(rsp_valid), n);
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (req_we[i]) mirror[req_addr[i*10 +: 10]] = req_wdata[i*18 +: 18];
                else sb.push_back('{cyc + 2, i, mirror[req_addr[i*10 +: 10]]});
            end
        end
        @(posedge clka);
        #1;
        cyc++;
    endtask

    initial begin
        rsta = 1'b1;
        clr_req();
        set_l(1'b0, 1'b0, 10'd0, 18'd0);
        @(posedge clka);
        #1;
        // reset: all requesters asking, nothing granted
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 10'(i), 18'd0);
        #1;
        chk("ram_rsta_in_reset", ram_rsta, 1'b1);
        step(4'b0000);
        step(4'b0000);
        rsta = 1'b0;

        // fairness: all four read continuously for 8 cycles
        maxw = 0;
        for (int i = 0; i < 4; i++) begin gcnt[i] = 0; wcnt[i] = 0; end
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin gcnt[i]++; wcnt[i] = 0; end
                else begin wcnt[i]++; if (wcnt[i] > maxw) maxw = wcnt[i]; end
            end
            step((c % 2 == 0) ? 4'b0011 : 4'b1100);
        end
        clr_req();
        for (int i = 0; i < 4; i++) chk("grant_count", gcnt[i], 4);
        chk("max_wait_le_2", maxw <= 2, 1'b1);
        step(4'b0000); step(4'b0000); step(4'b0000);

        // latency HIGH_PERFORMANCE: preload 0x155 then read it alone
        set_req(0, 1'b1, 1'b1, 10'd20, 18'h155);
        step(4'b0001);
        set_req(0, 1'b1, 1'b0, 10'd20, 18'd0);
        #1;
        chk("single_on_port_a", {ram_ena, ram_enb, ram_wea}, 3'b100);
        chk("ram_addra", ram_addra, 10'd20);
        step(4'b0001);
        clr_req();
        #1;
        chk("hp_rsp_early", rsp_valid, 4'b0000);
        step(4'b0000);
        chk("hp_rsp_valid", rsp_valid, 4'b0001);
        chk("hp_rsp_data", rsp_rdata[17:0], 18'h155);
        step(4'b0000);

        // latency LOW_LATENCY on the second instance
        set_l(1'b1, 1'b1, 10'd3, 18'h155);
        #1;
        chk("ll_ready_wr", l_req_ready, 4'b0001);
        step(4'b0000);
        set_l(1'b1, 1'b0, 10'd3, 18'd0);
        #1;
        chk("ll_ready_rd", l_req_ready, 4'b0001);
        chk("ll_rsp_early", l_rsp_valid, 4'b0000);
        step(4'b0000);
        set_l(1'b0, 1'b0, 10'd0, 18'd0);
        #1;
        chk("ll_rsp_valid", l_rsp_valid, 4'b0001);
        chk("ll_rsp_data", l_rsp_rdata[17:0], 18'h155);
        step(4'b0000);
        chk("ll_rsp_after", l_rsp_valid, 4'b0000);

        // reset one cycle after a read grant: response must vanish
        set_req(2, 1'b1, 1'b0, 10'd7, 18'd0);
        step(4'b0100);
        clr_req();
        rsta = 1'b1;
        sb.delete();
        step(4'b0000);
        step(4'b0000);
        rsta = 1'b0;
        for (int c = 0; c < 4; c++) step(4'b0000);

        // collision: req0 writes 5 while req1 reads 5 (ptr back at 0)
`ifdef DP_RAM_ARBITER_CONFLICT_CNT_EN
        #1;
        chk("conflict_cnt_zero", conflict_cnt, 16'd0);
`endif
        set_req(0, 1'b1, 1'b1, 10'd5, 18'h2AA);
        set_req(1, 1'b1, 1'b0, 10'd5, 18'd0);
        #1;
        chk("collide_ports", {ram_ena, ram_wea, ram_enb}, 3'b110);
        step(4'b0001);
`ifdef DP_RAM_ARBITER_CONFLICT_CNT_EN
        #1;
        chk("conflict_cnt_one", conflict_cnt, 16'd1);
`endif
        set_req(0, 1'b0, 1'b0, 10'd0, 18'd0);
        step(4'b0010);
        clr_req();
        step(4'b0000); step(4'b0000); step(4'b0000);

        // parallel: preload addr 7, then req2 reads 7 while req3 writes 9
        set_req(2, 1'b1, 1'b1, 10'd7, 18'h0F0);
        step(4'b0100);
        set_req(2, 1'b1, 1'b0, 10'd7, 18'd0);
        set_req(3, 1'b1, 1'b1, 10'd9, 18'h3C3);
        #1;
        chk("par_ports", {ram_ena, ram_wea, ram_enb, ram_web}, 4'b1110);
        chk("par_addrb", ram_addrb, 10'd7);
        step(4'b1100);
        clr_req();
        step(4'b0000);
        chk("par_rsp_only_req2", rsp_valid, 4'b0100);
        step(4'b0000);
        set_req(3, 1'b1, 1'b0, 10'd9, 18'd0);
        step(4'b1000);
        clr_req();
        step(4'b0000); step(4'b0000); step(4'b0000);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
